serial_fs_controller: RTL and testbench
=======================================

Name: serial_fs_controller

Overview:
- Bit-serial WIDTH-bit subtractor controller: computes diff = a - b - bin_init using a single 1-bit full-subtractor cell, one bit per clock, LSB first.
- The cell is the team's demux-based full subtractor: diff = a^b^bin, borrow = (~a&b) | (~a&bin) | (b&bin).
- The block owns operand shift registers, the borrow flip-flop, the bit counter and the start/busy/done handshake.
- It presents a registered multi-bit result to the surrounding datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2 to 32.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request pulse or level; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the edge that accepts start.
- b  input  WIDTH  subtrahend; sampled on the edge that accepts start.
- bin_init  input  1  initial borrow-in; sampled with a and b.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse: result valid and just updated.
- diff  output  WIDTH  registered difference; holds its value until the next completion.
- borrow_out  output  1  final borrow; 1 means a < b + bin_init (unsigned).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. On a reset edge:
  - state = IDLE, busy = 0, done = 0, diff = 0, borrow_out = 0.
  - Internal shift registers, borrow flip-flop and counter are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy = 0, done = 0.
  - If start = 1 at an edge: load sa <= a, sb <= b, brw <= bin_init, cnt <= 0, and go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy = 1), each edge:
  - d = sa[0]^sb[0]^brw.
  - brw <= borrow(sa[0], sb[0], brw).
  - sd <= {d, sd[WIDTH-1:1]}.
  - sa and sb shift right by one.
  - cnt <= cnt+1.
  - On the edge where cnt = WIDTH-1 (the last bit): diff <= {d, sd[WIDTH-1:1]}, borrow_out <= new borrow, go to DONE.
- DONE:
  - busy = 1, done = 1 for exactly this one cycle.
  - The next edge goes to IDLE unconditionally.
- Latency:
  - Let E0 be the edge that accepts start. done is high in the cycle following edge E0+WIDTH.
  - The next start can be accepted at edge E0+WIDTH+2.
  - With start held high, throughput is one result per WIDTH+2 cycles.
- Counter width is the minimum needed to hold WIDTH-1. No arithmetic wider than 1 bit; all subtraction is done through the 1-bit cell.
- Boundary conditions:
  - start while busy (RUN or DONE): ignored. a, b and bin_init changes during RUN have no effect.
  - diff and borrow_out change only on the completion edge. Between operations they hold the last result; they are never partially updated.
  - Reset mid-RUN or in DONE: the operation is abandoned, all outputs clear at that edge, and no done pulse is produced.
  - Reset and start in the same edge: reset wins and state stays IDLE.
  - Wrap-around: the result is modulo 2^WIDTH. borrow_out is the only indication of underflow.
  - No X on outputs after the first reset edge, regardless of input values.

Test Plan:
- Reset then idle: assert rst for 2 cycles -> busy = 0, done = 0, diff = 0x00, borrow_out = 0. start = 0 for 20 cycles -> no change.
- WIDTH = 8, a = 0x5A, b = 0x3C, bin_init = 0, start pulse -> done exactly 8 edges after acceptance, diff = 0x1E, borrow_out = 0.
- Underflow cases:
  - a = 0x10, b = 0x20, bin_init = 0 -> diff = 0xF0, borrow_out = 1.
  - a = 0x00, b = 0x00, bin_init = 1 -> diff = 0xFF, borrow_out = 1.
  - a = 0xFF, b = 0xFF, bin_init = 0 -> diff = 0x00, borrow_out = 0.
- Busy protection: start an op with a = 0x80, b = 0x01. During RUN, pulse start with a = 0x00, b = 0xFF -> result is 0x7F with borrow_out = 0, exactly one done pulse, and diff is unchanged from its previous value until the done cycle.
- Back-to-back: hold start = 1 while a/b are changed after each done -> a new op is accepted every 10 cycles (WIDTH+2) and each done reports the operands sampled at its own acceptance.
- Reset mid-operation: assert rst on the 4th RUN edge -> no done pulse, diff = 0, borrow_out = 0, busy = 0. A subsequent op with a = 0x03, b = 0x05 yields diff = 0xFE, borrow_out = 1.

Source files
------------

// File: rtl/serial_fs_controller.sv
// serial_fs_controller: bit-serial a - b - bin_init through a 1-bit full-subtractor cell, LSB first
//   clk, rst         : clock, synchronous active-high reset
//   start, a, b,
//   bin_init         : operation request and operands, sampled only in IDLE
//   busy, done       : busy in RUN/DONE, done pulses for the single cycle after completion
//   diff, borrow_out : registered result, updated only on the completion edge
module serial_fs_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, diff_q, diff_d;
  logic [WIDTH-2:0] sd_q, sd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d, bo_q, bo_d;
  logic             d, nb;
  logic [WIDTH-1:0] acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
    end
  end
  // sd_q keeps only the upper WIDTH-1 partial bits; the bit that would fall off the bottom is never used
  always_comb begin
    d       = sa_q[0] ^ sb_q[0] ^ brw_q;
    nb      = (~sa_q[0] & sb_q[0]) | (~sa_q[0] & brw_q) | (sb_q[0] & brw_q);
    acc     = {d, sd_q};
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        sa_d    = a;
        sb_d    = b;
        brw_d   = bin_init;
        cnt_d   = '0;
      end
      RUN: begin
        brw_d = nb;
        sd_d  = acc[WIDTH-1:1];
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          diff_d  = acc;
          bo_d    = nb;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign diff       = diff_q;
  assign borrow_out = bo_q;
endmodule

// File: tb/tb_serial_fs_controller.sv
// tb_serial_fs_controller: directed scoreboard bench for serial_fs_controller
module tb_serial_fs_controller;
  localparam int W = 8;
  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, bin_init = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;
  int           errors = 0, checks = 0;
  logic [W:0]   sb_q[$];

  always #5 clk = ~clk;

  serial_fs_controller #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin_init(bin_init),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a = x; b = y; bin_init = c; start = 1'b1;
    step();
    start = 1'b0;
    sb_q.push_back(model(x, y, c));
  endtask

  // Called right after the accepting edge; poke >= 0 drives a stray start with new operands mid-RUN.
  task automatic wait_done(input string tag, input int poke);
    logic [W-1:0] pre_d;
    logic         pre_b, held;
    logic [W:0]   exp;
    int           n;
    pre_d = diff; pre_b = borrow_out; held = 1'b1; n = 0;
    chk({tag, "_busy"}, busy, 1);
    while (done !== 1'b1 && n < 40) begin
      if (diff !== pre_d || borrow_out !== pre_b) held = 1'b0;
      if (poke >= 0) begin
        start = (n == poke);
        if (n == poke) begin a = '0; b = '1; end
      end
      step();
      n++;
    end
    if (poke >= 0) start = 1'b0;
    chk({tag, "_lat"}, n, W);
    chk({tag, "_hold"}, held, 1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    chk({tag, "_diff"}, diff, exp[W-1:0]);
    chk({tag, "_bo"}, borrow_out, exp[W]);
  endtask

  task automatic quiet(input string tag, input int cycles);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    logic [W-1:0] ta[4], tb[4];
    logic ok;
    ta = '{8'h11, 8'hC3, 8'h00, 8'h7E};
    tb = '{8'h22, 8'h42, 8'h01, 8'h7E};
    step(); step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bo", borrow_out, 0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) ok = 1'b0;
    end
    chk("idle_stable", ok, 1);

    accept(8'h5A, 8'h3C, 1'b0); wait_done("basic", -1);
    step(); chk("basic_pulse", done, 0); chk("basic_idle", busy, 0);
    accept(8'h10, 8'h20, 1'b0); wait_done("uf1", -1); step();
    accept(8'h00, 8'h00, 1'b1); wait_done("uf2", -1); step();
    accept(8'hFF, 8'hFF, 1'b0); wait_done("eq", -1); step();

    accept(8'h80, 8'h01, 1'b0); wait_done("busyprot", 3);
    step(); chk("busyprot_pulse", done, 0);
    quiet("busyprot_quiet", 12);

    a = ta[0]; b = tb[0]; bin_init = 1'b0; start = 1'b1;
    step();
    sb_q.push_back(model(ta[0], tb[0], 1'b0));
    for (int i = 0; i < 4; i++) begin
      wait_done($sformatf("b2b%0d", i), -1);
      if (i < 3) begin
        a = ta[i+1]; b = tb[i+1];
      end else start = 1'b0;
      step();
      chk($sformatf("b2b%0d_gap", i), busy, 0);
      step();
      chk($sformatf("b2b%0d_next", i), busy, (i < 3) ? 1 : 0);
      if (i < 3) sb_q.push_back(model(ta[i+1], tb[i+1], 1'b0));
    end

    accept(8'h77, 8'h11, 1'b0);
    void'(sb_q.pop_back());
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_bo", borrow_out, 0);
    quiet("midrst_quiet", 12);
    accept(8'h03, 8'h05, 1'b0); wait_done("post", -1); step();

    rst = 1'b1; start = 1'b1; a = 8'h44; b = 8'h11;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_diff", diff, 0);
    quiet("rst_start_quiet", 3);

    for (int i = 0; i < 4; i++) begin
      accept(W'($urandom), W'($urandom), 1'($urandom));
      wait_done($sformatf("rnd%0d", i), -1);
      step();
    end

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
